mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory bus between the IF stage (instruction fetch) and the MEM stage (load/store).
//  Arbitrates between the two, registers the granted request onto the bus and waits for a variable-latency ack.
//  Returns the read data and a one-cycle ready pulse to the owner.
//  Generates stall_f/stall_m, which drive pcenr en and the IF/ID and EX/MEM flopenrc en of the pipeline.
// PARAMETERS
//  ADDR_W   32  address width (= `ADDR_SIZE)
//  DATA_W   32  data width (= `XLEN)
//  TIMEOUT  16  max BUSY cycles without bus_ack before abort; legal range 2..255
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  if_req     in   1       fetch request; held with if_addr until if_ready
//  if_addr    in   ADDR_W  fetch address
//  if_rdata   out  DATA_W  fetched word, valid while if_ready=1
//  if_ready   out  1       one-cycle completion pulse for fetch
//  mem_req    in   1       data request; held with payload until mem_ready
//  mem_we     in   1       1=store, 0=load
//  mem_addr   in   ADDR_W  data address
//  mem_wdata  in   DATA_W  store data
//  mem_be     in   4       byte enables (access pattern)
//  mem_rdata  out  DATA_W  load data, valid while mem_ready=1
//  mem_ready  out  1       one-cycle completion pulse for data
//  bus_err    out  1       with a ready pulse: access timed out
//  bus_req    out  1       bus request, high throughout BUSY
//  bus_we     out  1       latched write flag
//  bus_addr   out  ADDR_W  latched address
//  bus_wdata  out  DATA_W  latched store data (0 for fetch)
//  bus_be     out  4       latched byte enables (4'b1111 for fetch)
//  bus_ack    in   1       memory completion; bus_rdata valid with it
//  bus_rdata  in   DATA_W  memory read data
//  stall_f    out  1       if_req & ~if_ready (combinational)
//  stall_m    out  1       mem_req & ~mem_ready (combinational)
// BEHAVIOUR
//  - Reset: state=IDLE, rr=0 (D preferred), tcnt=0. All registered outputs are 0.
//    Reset is async and may abort a transfer in flight; bus_req drops immediately and no ready pulse is issued.
//  - FSM: IDLE, BUSY_I, BUSY_D. bus_req = (state != IDLE). Bus fields come from registers loaded at grant.
//  - IDLE: a requester is eligible when req=1 and its ready=0 this cycle, so a completed request is never re-granted.
//    Only D eligible -> BUSY_D. Only I eligible -> BUSY_I.
//    Both eligible -> grant by rr (rr=0: D, rr=1: I); rr flips to the opposite side after each grant.
//    A lone requester does not change rr.
//  - BUSY_x, bus_ack=1:
//    * Next cycle: x_ready=1, x_rdata=bus_rdata (0 for stores), bus_err=0, state=IDLE.
//    * Minimum latency: req cycle 0 -> bus_req cycle 1 -> ack cycle 1 -> ready cycle 2.
//  - BUSY_x, no ack: tcnt increments. At tcnt==TIMEOUT-1 without ack:
//    next cycle x_ready=1, bus_err=1, x_rdata=0, state=IDLE.
//    bus_ack in the same cycle wins (normal completion). tcnt clears on every grant.
//  - Ready/rdata/err are registered one-cycle pulses; rdata returns to 0 when ready drops.
//  - bus_ack while IDLE is ignored. Changes to the payload during BUSY are ignored, because the bus fields are latched.
//  - Ready for one side and a grant to the other can occur in the same cycle (back-to-back throughput).
// TESTING
//  1. Fetch only: if_addr=0x100, ack 1 cycle after bus_req with rdata=0x00500093
//     -> bus_addr=0x100, bus_be=4'hF, if_ready@cycle2, if_rdata=0x00500093, stall_f 1 during cycles 0-1.
//  2. Simultaneous if_req and mem_req (load 0x2000) after reset
//     -> D granted first; I granted on the cycle mem_ready pulses; rr=1 then 0.
//  3. Store: mem_we=1, addr=0x2004, wdata=0xDEADBEEF, be=4'b0011, ack after 3 cycles
//     -> bus fields match, mem_rdata=0, mem_ready once, no re-grant while mem_req still high.
//  4. No ack with TIMEOUT=16 -> bus_req high 16 cycles, then mem_ready=1 and bus_err=1, state IDLE.
//     Ack on the 16th cycle -> normal completion, bus_err=0.
//  5. Reset asserted mid-BUSY_D -> bus_req=0 immediately, no ready pulse; after release, a pending if_req is granted normally.
//  6. Continuous both-side requests with 1-cycle ack -> grants strictly alternate D, I, D, I and neither stalls more than 4 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and load/store.
// Grants one requester at a time, latches its request, and returns data with a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stall_f,
  output logic              stall_m
);

  localparam int unsigned TCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t            state;
  logic              rr;
  logic [TCNT_W-1:0] tcnt;
  logic              i_elig;
  logic              d_elig;
  logic              grant_d;
  logic              tmo;

  // A side whose ready is high this cycle has just completed and must not be granted again
  assign i_elig  = if_req & ~if_ready;
  assign d_elig  = mem_req & ~mem_ready;
  assign grant_d = d_elig & (~i_elig | ~rr);
  assign tmo     = (tcnt == TCNT_W'(TIMEOUT - 1));

  assign stall_f = if_req & ~if_ready;
  assign stall_m = mem_req & ~mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr        <= 1'b0;
      tcnt      <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= 4'h0;
      if_ready  <= 1'b0;
      if_rdata  <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      if_rdata  <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= BUSY_D;
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_be    <= mem_be;
            tcnt      <= '0;
            if (i_elig) rr <= 1'b1;
          end else if (i_elig) begin
            state     <= BUSY_I;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
            bus_be    <= 4'hF;
            tcnt      <= '0;
            if (d_elig) rr <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          // An ack on the final allowed cycle still counts as a normal completion
          if (bus_ack || tmo) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            bus_err <= ~bus_ack;
            if (state == BUSY_I) begin
              if_ready <= 1'b1;
              if_rdata <= bus_ack ? bus_rdata : '0;
            end else begin
              mem_ready <= 1'b1;
              mem_rdata <= (bus_ack && !bus_we) ? bus_rdata : '0;
            end
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              bus_err;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              stall_f;
  logic              stall_m;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1);
  end

  // Model state for the randomized engine
  bit          m_busy, m_owner_d, m_rr, exp_if_rdy, exp_mem_rdy, exp_err, exp_we;
  bit          prev_if_rdy, prev_mem_rdy;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  int          m_cnt, ack_at, last_obs, grants, run_f, run_m, stall_max;

  // Leaves reset released at a falling edge; caller drives that cycle's inputs
  task automatic do_reset();
    reset = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_be = 4'h0; bus_ack = 1'b0; bus_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b1; mem_req = 1'b1; bus_ack = 1'b1;
    if_addr = 32'h1234; mem_addr = 32'h5678; mem_be = 4'hF; mem_we = 1'b1;
    mem_wdata = 32'hFFFF_FFFF; bus_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b exp 0", bus_req); end
    checks++; if ({if_ready, mem_ready, bus_err} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b exp 000", {if_ready, mem_ready, bus_err}); end
    checks++; if ({bus_we, bus_addr, bus_wdata, bus_be, if_rdata, mem_rdata} !== '0) begin
      errors++; $display("FAIL reset_regs got %h exp 0", {bus_we, bus_addr, bus_wdata, bus_be, if_rdata, mem_rdata}); end
  endtask

  task automatic test_fetch();
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;                          // cycle 0
    #1;
    checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0 got %b exp 1", stall_f); end
    @(negedge clk);                                            // cycle 1
    checks++; if ({bus_req, bus_we, bus_addr, bus_wdata, bus_be} !== {1'b1, 1'b0, 32'h100, 32'h0, 4'hF}) begin
      errors++; $display("FAIL fetch_bus got %h exp %h", {bus_req, bus_we, bus_addr, bus_wdata, bus_be},
                         {1'b1, 1'b0, 32'h100, 32'h0, 4'hF}); end
    checks++; if ({if_ready, stall_f} !== 2'b01) begin errors++; $display("FAIL fetch_c1 got %b exp 01", {if_ready, stall_f}); end
    bus_ack = 1'b1; bus_rdata = 32'h0050_0093;
    @(negedge clk);                                            // cycle 2
    bus_ack = 1'b0;
    checks++; if ({if_ready, if_rdata, bus_err, bus_req} !== {1'b1, 32'h0050_0093, 1'b0, 1'b0}) begin
      errors++; $display("FAIL fetch_ready got %h exp %h", {if_ready, if_rdata, bus_err, bus_req},
                         {1'b1, 32'h0050_0093, 1'b0, 1'b0}); end
    #1;
    checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL fetch_stall_c2 got %b exp 0", stall_f); end
    @(negedge clk);                                            // cycle 3
    if_req = 1'b0;
    checks++; if ({bus_req, if_ready, if_rdata} !== '0) begin
      errors++; $display("FAIL fetch_after got %h exp 0", {bus_req, if_ready, if_rdata}); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_req = 1'b1; if_addr = 32'h300;                          // cycle 0
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_be = 4'hF;
    @(negedge clk);                                            // cycle 1: data side first
    checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h2000}) begin
      errors++; $display("FAIL simul_first got %h exp %h", {bus_req, bus_addr}, {1'b1, 32'h2000}); end
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    @(negedge clk);                                            // cycle 2: mem_ready, fetch granted
    bus_ack = 1'b0;
    checks++; if ({mem_ready, mem_rdata, if_ready} !== {1'b1, 32'h1111_1111, 1'b0}) begin
      errors++; $display("FAIL simul_mready got %h exp %h", {mem_ready, mem_rdata, if_ready}, {1'b1, 32'h1111_1111, 1'b0}); end
    @(negedge clk);                                            // cycle 3
    mem_req = 1'b0;
    checks++; if ({bus_req, bus_addr, bus_be} !== {1'b1, 32'h300, 4'hF}) begin
      errors++; $display("FAIL simul_second got %h exp %h", {bus_req, bus_addr, bus_be}, {1'b1, 32'h300, 4'hF}); end
    bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
    @(negedge clk);                                            // cycle 4
    bus_ack = 1'b0;
    checks++; if ({if_ready, if_rdata} !== {1'b1, 32'h2222_2222}) begin
      errors++; $display("FAIL simul_iready got %h exp %h", {if_ready, if_rdata}, {1'b1, 32'h2222_2222}); end
    @(negedge clk);                                            // cycle 5: new contention, fetch preferred
    if_addr = 32'h304; mem_req = 1'b1; mem_addr = 32'h2008;
    @(negedge clk);                                            // cycle 6
    checks++; if (bus_addr !== 32'h304) begin errors++; $display("FAIL simul_rr1 got %h exp 304", bus_addr); end
    bus_ack = 1'b1;
    @(negedge clk);                                            // cycle 7: lone data grant
    bus_ack = 1'b0;
    @(negedge clk);                                            // cycle 8
    if_req = 1'b0;
    bus_ack = 1'b1;
    @(negedge clk);                                            // cycle 9: mem_ready
    bus_ack = 1'b0;
    @(negedge clk);                                            // cycle 10: contention, data preferred
    if_req = 1'b1; if_addr = 32'h308; mem_addr = 32'h200C;
    @(negedge clk);                                            // cycle 11
    checks++; if (bus_addr !== 32'h200C) begin errors++; $display("FAIL simul_rr0 got %h exp 200c", bus_addr); end
  endtask

  task automatic test_store();
    int pulses;
    do_reset();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2004; mem_wdata = 32'hDEAD_BEEF; mem_be = 4'b0011;
    @(negedge clk);                                            // cycle 1
    checks++; if ({bus_req, bus_we, bus_addr, bus_wdata, bus_be} !== {1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011}) begin
      errors++; $display("FAIL store_bus got %h exp %h", {bus_req, bus_we, bus_addr, bus_wdata, bus_be},
                         {1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011}); end
    @(negedge clk);                                            // cycle 2: payload disturbed
    mem_addr = 32'hFFFF_0000; mem_wdata = 32'h0; mem_be = 4'hF;
    @(negedge clk);                                            // cycle 3
    checks++; if ({bus_addr, bus_wdata, bus_be, mem_ready} !== {32'h2004, 32'hDEAD_BEEF, 4'b0011, 1'b0}) begin
      errors++; $display("FAIL store_latched got %h exp %h", {bus_addr, bus_wdata, bus_be, mem_ready},
                         {32'h2004, 32'hDEAD_BEEF, 4'b0011, 1'b0}); end
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);                                            // cycle 4
    bus_ack = 1'b0;
    checks++; if ({mem_ready, mem_rdata, bus_err} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL store_ready got %h exp %h", {mem_ready, mem_rdata, bus_err}, {1'b1, 32'h0, 1'b0}); end
    pulses = 1;
    @(negedge clk);                                            // cycle 5
    mem_req = 1'b0;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL store_regrant got %b exp 0", bus_req); end
    for (int i = 0; i < 4; i++) begin
      if (mem_ready) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL store_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_timeout(input bit ack_last);
    int  n;
    bit  seen;
    n = 0; seen = 1'b0;
    do_reset();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000; mem_be = 4'hF; bus_rdata = 32'h5A5A_1234;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (mem_ready) seen = 1'b1;
      else if (bus_req) begin
        n++;
        if (ack_last && n == int'(TIMEOUT)) bus_ack = 1'b1;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL tmo_no_ready ack_last=%0d got 0 exp 1", ack_last); end
    checks++; if (n != int'(TIMEOUT)) begin errors++; $display("FAIL tmo_busy_cycles ack_last=%0d got %0d exp %0d", ack_last, n, TIMEOUT); end
    checks++; if ({bus_err, mem_rdata, bus_req} !== {!ack_last, ack_last ? 32'h5A5A_1234 : 32'h0, 1'b0}) begin
      errors++; $display("FAIL tmo_result ack_last=%0d got %h exp %h", ack_last, {bus_err, mem_rdata, bus_req},
                         {!ack_last, ack_last ? 32'h5A5A_1234 : 32'h0, 1'b0}); end
    @(negedge clk);
    mem_req = 1'b0; bus_ack = 1'b1;                            // stray ack while idle
    @(negedge clk);
    bus_ack = 1'b0;
    @(negedge clk);
    checks++; if ({bus_req, mem_ready, if_ready, bus_err} !== 4'b0000) begin
      errors++; $display("FAIL tmo_idle_ack got %b exp 0000", {bus_req, mem_ready, if_ready, bus_err}); end
  endtask

  task automatic test_reset_midbusy();
    do_reset();
    mem_req = 1'b1; mem_addr = 32'h4000; mem_be = 4'hF;        // cycle 0
    @(negedge clk);                                            // cycle 1
    if_req = 1'b1; if_addr = 32'h500;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b exp 1", bus_req); end
    @(negedge clk);                                            // cycle 2
    reset = 1'b1; mem_req = 1'b0;
    #1;
    checks++; if ({bus_req, bus_addr} !== '0) begin errors++; $display("FAIL rmid_drop got %h exp 0", {bus_req, bus_addr}); end
    @(negedge clk);                                            // cycle 3
    reset = 1'b0;
    checks++; if ({mem_ready, if_ready} !== 2'b00) begin errors++; $display("FAIL rmid_no_ready got %b exp 00", {mem_ready, if_ready}); end
    @(negedge clk);                                            // cycle 4
    checks++; if ({bus_req, bus_addr, mem_ready} !== {1'b1, 32'h500, 1'b0}) begin
      errors++; $display("FAIL rmid_regrant got %h exp %h", {bus_req, bus_addr, mem_ready}, {1'b1, 32'h500, 1'b0}); end
    bus_ack = 1'b1; bus_rdata = 32'h0000_0013;
    @(negedge clk);                                            // cycle 5
    bus_ack = 1'b0;
    checks++; if ({if_ready, if_rdata, mem_ready} !== {1'b1, 32'h13, 1'b0}) begin
      errors++; $display("FAIL rmid_fetch got %h exp %h", {if_ready, if_rdata, mem_ready}, {1'b1, 32'h13, 1'b0}); end
  endtask

  // md=0: random traffic and latencies; md=1: both sides always requesting, ack in first busy cycle
  task automatic run_engine(input int ncyc, input int md);
    bit e_i, e_d, done, n_if, n_mem, n_err;
    logic [31:0] n_rdata;
    int p;
    p = (md == 1) ? 100 : 45;
    do_reset();
    m_busy = 0; m_rr = 0; m_owner_d = 0; exp_if_rdy = 0; exp_mem_rdy = 0; exp_err = 0;
    exp_rdata = '0; prev_if_rdy = 0; prev_mem_rdy = 0; m_cnt = 0; ack_at = 0;
    last_obs = -1; grants = 0; run_f = 0; run_m = 0; stall_max = 0;
    for (int c = 0; c < ncyc; c++) begin
      checks++; if (if_ready !== exp_if_rdy) begin errors++; $display("FAIL eng_if_ready cyc %0d got %b exp %b", c, if_ready, exp_if_rdy); end
      checks++; if (mem_ready !== exp_mem_rdy) begin errors++; $display("FAIL eng_mem_ready cyc %0d got %b exp %b", c, mem_ready, exp_mem_rdy); end
      checks++; if (if_rdata !== (exp_if_rdy ? exp_rdata : 32'h0)) begin
        errors++; $display("FAIL eng_if_rdata cyc %0d got %h exp %h", c, if_rdata, exp_if_rdy ? exp_rdata : 32'h0); end
      checks++; if (mem_rdata !== (exp_mem_rdy ? exp_rdata : 32'h0)) begin
        errors++; $display("FAIL eng_mem_rdata cyc %0d got %h exp %h", c, mem_rdata, exp_mem_rdy ? exp_rdata : 32'h0); end
      checks++; if (bus_err !== (exp_err && (exp_if_rdy || exp_mem_rdy))) begin
        errors++; $display("FAIL eng_bus_err cyc %0d got %b exp %b", c, bus_err, exp_err && (exp_if_rdy || exp_mem_rdy)); end
      checks++; if (bus_req !== m_busy) begin errors++; $display("FAIL eng_bus_req cyc %0d got %b exp %b", c, bus_req, m_busy); end
      if (m_busy) begin
        checks++; if ({bus_we, bus_addr, bus_wdata, bus_be} !== {exp_we, exp_addr, exp_wdata, exp_be}) begin
          errors++; $display("FAIL eng_bus_fields cyc %0d got %h exp %h", c, {bus_we, bus_addr, bus_wdata, bus_be},
                             {exp_we, exp_addr, exp_wdata, exp_be}); end
        if (m_cnt == 0) begin
          grants++;
          if (md == 1) begin
            checks++; if (last_obs == int'(bus_addr[31])) begin
              errors++; $display("FAIL b2b_alternate cyc %0d got owner %0d exp %0d", c, bus_addr[31], 1 - last_obs); end
          end
          last_obs = int'(bus_addr[31]);
        end
      end
      // Requesters hold through their ready cycle and move on at the next one
      if (!if_req || prev_if_rdy) begin
        if_req = int'($urandom_range(99)) < p;
        if_addr = {1'b0, 29'($urandom), 2'b00};
      end
      if (!mem_req || prev_mem_rdy) begin
        mem_req = int'($urandom_range(99)) < p;
        mem_we = 1'($urandom_range(1));
        mem_addr = {1'b1, 29'($urandom), 2'b00};
        mem_wdata = $urandom;
        mem_be = 4'($urandom_range(15, 1));
      end
      prev_if_rdy = if_ready; prev_mem_rdy = mem_ready;
      n_if = 0; n_mem = 0; n_err = 0; n_rdata = '0; done = 0;
      bus_ack = 1'b0; bus_rdata = $urandom;
      if (m_busy) begin
        if (m_cnt == ack_at) begin
          bus_ack = 1'b1; done = 1;
          n_rdata = (m_owner_d && exp_we) ? 32'h0 : bus_rdata;
        end else if (m_cnt == int'(TIMEOUT) - 1) begin
          done = 1; n_err = 1;
        end
        if (done) begin
          n_if = !m_owner_d; n_mem = m_owner_d; m_busy = 0;
        end else m_cnt++;
      end else begin
        if (md == 0 && $urandom_range(7) == 0) bus_ack = 1'b1;
        e_i = if_req && !if_ready;
        e_d = mem_req && !mem_ready;
        if (e_i || e_d) begin
          m_owner_d = e_d && (!e_i || !m_rr);
          if (e_i && e_d) m_rr = m_owner_d;
          if (m_owner_d) begin
            exp_we = mem_we; exp_addr = mem_addr; exp_wdata = mem_wdata; exp_be = mem_be;
          end else begin
            exp_we = 0; exp_addr = if_addr; exp_wdata = '0; exp_be = 4'hF;
          end
          m_busy = 1; m_cnt = 0;
          if (md == 1) ack_at = 0;
          else ack_at = ($urandom_range(11) == 0) ? -1 : int'($urandom_range(5));
        end
      end
      exp_if_rdy = n_if; exp_mem_rdy = n_mem; exp_err = n_err; exp_rdata = n_rdata;
      #1;
      checks++; if ({stall_f, stall_m} !== {if_req && !if_ready, mem_req && !mem_ready}) begin
        errors++; $display("FAIL eng_stall cyc %0d got %b exp %b", c, {stall_f, stall_m},
                           {if_req && !if_ready, mem_req && !mem_ready}); end
      run_f = stall_f ? run_f + 1 : 0;
      run_m = stall_m ? run_m + 1 : 0;
      if (run_f > stall_max) stall_max = run_f;
      if (run_m > stall_max) stall_max = run_m;
      @(negedge clk);
    end
    if (md == 1) begin
      checks++; if (stall_max > 4) begin errors++; $display("FAIL b2b_stall_max got %0d exp <=4", stall_max); end
      checks++; if (grants < ncyc / 3) begin errors++; $display("FAIL b2b_throughput got %0d grants exp >=%0d", grants, ncyc / 3); end
    end
    bus_ack = 1'b0; if_req = 1'b0; mem_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_engine(400, 1);
  endtask

  task automatic test_random();
    run_engine(3000, 0);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_midbusy();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
